// File: rtl/img2col_pkg.sv
// Shared types and helpers for the image-to-column streamer.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package img2col_pkg;

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Output side length for a square image of side img_sz, kernel k, stride 1 or 2.
    function automatic logic [CNT_W-1:0] out_dim(input logic [CNT_W-1:0] img_sz,
                                                 input logic [2:0]       k,
                                                 input logic             stride);
        logic [CNT_W-1:0] span;
        span = img_sz - {{(CNT_W-3){1'b0}}, k};
        return (span >> stride) + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/img2col_addr_gen.sv
// Raster position counters (pc fastest) and final-position flag for one tile.
// Latency: next position is visible combinationally on pr_nxt/pc_nxt; counters update on the clock.
// Backpressure: counters move only on advance, so a stalled consumer freezes the position.
module img2col_addr_gen
    import img2col_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] od,
    output logic [CNT_W-1:0] pr_nxt,
    output logic [CNT_W-1:0] pc_nxt,
    output logic             last
);

    logic [CNT_W-1:0] pr_q, pr_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] od_m1;

    assign od_m1 = od - {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        pr_d = pr_q;
        pc_d = pc_q;
        if (clear) begin
            pr_d = '0;
            pc_d = '0;
        end else if (advance) begin
            if (pc_q == od_m1) begin
                pc_d = '0;
                pr_d = (pr_q == od_m1) ? '0 : pr_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                pc_d = pc_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pr_q <= '0;
            pc_q <= '0;
        end else begin
            pr_q <= pr_d;
            pc_q <= pc_d;
        end
    end

    assign pr_nxt = pr_d;
    assign pc_nxt = pc_d;
    assign last   = (pr_q == od_m1) && (pc_q == od_m1);

endmodule

// File: rtl/img2col_stream.sv
// Captures one multi-channel square tile and streams its receptive-field columns in raster order.
// Latency: first column valid one cycle after capture; one column per cycle while out_ready is high.
// Backpressure: out_ready low holds out_cols/out_last/position; in_ready is low until the last column is taken.
module img2col_stream
    import img2col_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG    = 5,
    parameter int CH     = 1,
    parameter int K_MAX  = 3,
    parameter int COL_N  = CH * K_MAX * K_MAX
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic [2:0]                                   k,
    input  logic                                         stride,
    input  logic [CH-1:0][IMG-1:0][IMG-1:0][DATA_W-1:0]  img,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [COL_N-1:0][DATA_W-1:0]                 out_cols,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_last,
    output logic                                         cfg_err
);

    typedef logic [CH-1:0][IMG-1:0][IMG-1:0][DATA_W-1:0] img_t;
    typedef logic [COL_N-1:0][DATA_W-1:0]                col_t;

    localparam int CW = (CH > 1)    ? $clog2(CH)    : 1;
    localparam int RW = (IMG > 1)   ? $clog2(IMG)   : 1;
    localparam int EW = (COL_N > 1) ? $clog2(COL_N) : 1;

    state_t     state_q, state_d;
    img_t       tile_q, tile_d;
    logic [2:0] k_q, k_d;
    logic       stride_q, stride_d;
    col_t       cols_q, cols_d;
    logic       cfg_err_q, cfg_err_d;

    logic             cfg_ok;
    logic             capture;
    logic             advance;
    logic             pos_last;
    logic [CNT_W-1:0] od;
    logic [CNT_W-1:0] pr_nxt, pc_nxt;

    // Element e = (c*k + r)*k + s; slots beyond CH*k*k stay zero.
    function automatic col_t gather(input img_t             t,
                                    input logic [2:0]       kk,
                                    input logic             st,
                                    input logic [CNT_W-1:0] pr,
                                    input logic [CNT_W-1:0] pc);
        col_t res;
        int   ki, idx, row, col;
        res = '0;
        ki  = int'(kk);
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < K_MAX; r++) begin
                for (int s = 0; s < K_MAX; s++) begin
                    idx = (c * ki + r) * ki + s;
                    row = (int'(pr) << st) + r;
                    col = (int'(pc) << st) + s;
                    if (r < ki && s < ki && row < IMG && col < IMG)
                        res[EW'(idx)] = t[CW'(c)][RW'(row)][RW'(col)];
                end
            end
        end
        return res;
    endfunction

    assign cfg_ok    = (k != 3'd0) && (int'(k) <= K_MAX) && (int'(k) <= IMG);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign capture   = in_ready && in_valid && cfg_ok;
    assign advance   = out_valid && out_ready;
    assign od        = out_dim(CNT_W'(IMG), k_q, stride_q);

    img2col_addr_gen u_addr_gen (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (capture),
        .advance (advance),
        .od      (od),
        .pr_nxt  (pr_nxt),
        .pc_nxt  (pc_nxt),
        .last    (pos_last)
    );

    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        k_d       = k_q;
        stride_d  = stride_q;
        cols_d    = cols_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (cfg_ok) begin
                        tile_d   = img;
                        k_d      = k;
                        stride_d = stride;
                        // Column (0,0) straight from the input so it is ready the next cycle.
                        cols_d   = gather(img, k, stride, '0, '0);
                        state_d  = EMIT;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (advance) begin
                    if (pos_last) begin
                        cols_d  = '0;
                        state_d = IDLE;
                    end else begin
                        cols_d = gather(tile_q, k_q, stride_q, pr_nxt, pc_nxt);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            tile_q    <= '0;
            k_q       <= '0;
            stride_q  <= 1'b0;
            cols_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            k_q       <= k_d;
            stride_q  <= stride_d;
            cols_q    <= cols_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out_cols = cols_q;
    assign out_last = out_valid && pos_last;
    assign cfg_err  = cfg_err_q;

endmodule
